// File: rtl/data_memory_ctrl.sv
//------------------------------------------------------------------------------
// Module   : data_memory_ctrl
// Purpose  : Single-port word memory behind an IDLE/WAIT/ACCESS handshake with
//            byte-enabled writes. Define DMEM_RANGE_CHECK_EN for address checks.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module data_memory_ctrl #(
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 16,
   parameter int DEPTH       = 512,
   parameter int WAIT_STATES = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    req,
   input  logic                    write,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic [DATA_WIDTH-1:0]   data_bus_write,
   input  logic [DATA_WIDTH/8-1:0] byte_en,
   output logic                    ready,
   output logic [DATA_WIDTH-1:0]   data_bus_read,
   output logic                    valid,
   output logic                    err
);

   localparam int          c_IDX_W    = $clog2(DEPTH);
   localparam int          c_NB       = DATA_WIDTH / 8;
   localparam logic [3:0]  c_WAIT_CNT = 4'(WAIT_STATES);

   localparam logic [1:0]  c_IDLE   = 2'd0;
   localparam logic [1:0]  c_WAIT   = 2'd1;
   localparam logic [1:0]  c_ACCESS = 2'd2;

   logic [1:0]            r_state;
   logic [1:0]            w_next_state;
   logic [3:0]            r_cnt;
   logic                  r_write;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [c_NB-1:0]       r_be;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_valid;
   logic                  w_accept;
   logic                  w_access;
   logic                  w_in_range;
   logic [c_IDX_W-1:0]    w_idx;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE: begin
            if (req) begin
               w_next_state = (WAIT_STATES > 0) ? c_WAIT : c_ACCESS;
            end
         end
         c_WAIT: begin
            if (r_cnt <= 4'd1) begin
               w_next_state = c_ACCESS;
            end
         end
         c_ACCESS: w_next_state = c_IDLE;
         default:  w_next_state = c_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      ready    = (r_state == c_IDLE);
      w_access = (r_state == c_ACCESS);
      w_accept = ready & req;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt <= 4'd0;
      end else if (w_accept) begin
         r_cnt <= c_WAIT_CNT;
      end else if (r_state == c_WAIT) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   // Request fields are captured only on the accept edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
      end else if (w_accept) begin
         r_write <= write;
         r_addr  <= address;
         r_wdata <= data_bus_write;
         r_be    <= byte_en;
      end
   end

   assign w_idx = r_addr[c_IDX_W-1:0];

`ifdef DMEM_RANGE_CHECK_EN
   generate
      if (ADDR_WIDTH > c_IDX_W) begin : g_range
         assign w_in_range = ~|r_addr[ADDR_WIDTH-1:c_IDX_W];
      end else begin : g_range_full
         assign w_in_range = 1'b1;
      end
   endgenerate

   logic r_err;
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_access & ~w_in_range;
      end
   end
   assign err = r_err;
`else
   // Upper address bits are deliberately dropped: accesses wrap modulo DEPTH.
   assign w_in_range = 1'b1;
   generate
      if (ADDR_WIDTH > c_IDX_W) begin : g_unused
         logic w_unused_addr;
         assign w_unused_addr = ^r_addr[ADDR_WIDTH-1:c_IDX_W];
      end
   endgenerate
   assign err = 1'b0;
`endif

   // Storage has no reset so contents survive a reset pulse.
   always_ff @(posedge clock) begin
      if (w_access && r_write && w_in_range) begin
         for (int b = 0; b < c_NB; b++) begin
            if (r_be[b]) begin
               r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_valid <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_valid <= w_access;
         if (w_access && !r_write) begin
            r_rdata <= w_in_range ? r_mem[w_idx] : '0;
         end
      end
   end

   assign valid         = r_valid;
   assign data_bus_read = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_data_memory_ctrl
// Purpose  : Self-checking bench for data_memory_ctrl (WAIT_STATES=2) against a
//            word-array reference model; honours DMEM_RANGE_CHECK_EN.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_data_memory_ctrl;

   localparam int DW    = 16;
   localparam int AW    = 16;
   localparam int DEPTH = 512;
   localparam int WS    = 2;
   localparam int LAT   = WS + 2;
`ifdef DMEM_RANGE_CHECK_EN
   localparam bit RANGE_CHK = 1'b1;
`else
   localparam bit RANGE_CHK = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          req = 1'b0;
   logic          write = 1'b0;
   logic [AW-1:0] address = '0;
   logic [DW-1:0] data_bus_write = '0;
   logic [1:0]    byte_en = '0;
   logic          ready;
   logic [DW-1:0] data_bus_read;
   logic          valid;
   logic          err;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   logic [DW-1:0] model_mem [DEPTH];
   logic [DW-1:0] model_last_rd = '0;

   data_memory_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH),
      .WAIT_STATES(WS)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .req           (req),
      .write         (write),
      .address       (address),
      .data_bus_write(data_bus_write),
      .byte_en       (byte_en),
      .ready         (ready),
      .data_bus_read (data_bus_read),
      .valid         (valid),
      .err           (err)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: apply one operation to the word array and predict outputs.
   task automatic model_op(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [1:0] be, output logic [DW-1:0] exp_rd,
                           output logic exp_err);
      int idx;
      bit ok;
      idx = int'(a) % DEPTH;
      ok  = !RANGE_CHK || (int'(a) < DEPTH);
      if (wr) begin
         if (ok) begin
            for (int b = 0; b < 2; b++) begin
               if (be[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
            end
         end
      end else begin
         model_last_rd = ok ? model_mem[idx] : '0;
      end
      exp_rd  = model_last_rd;
      exp_err = !ok;
   endtask

   // Issue one request, scramble inputs after accept, observe completion.
   task automatic drive_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [1:0] be, output int lat, output int rdy_low,
                            output logic [DW-1:0] rd, output logic e);
      @(negedge clock);
      req = 1'b1; write = wr; address = a; data_bus_write = d; byte_en = be;
      @(posedge clock);
      #1;
      req = 1'b0;
      write = 1'($urandom);
      address = AW'($urandom);
      data_bus_write = DW'($urandom);
      byte_en = 2'($urandom);
      lat = 0;
      rdy_low = 0;
      while (lat < 20) begin
         @(negedge clock);
         lat++;
         if (!ready) rdy_low++;
         if (valid) break;
      end
      rd = data_bus_read;
      e  = err;
   endtask

   task automatic test_reset();
      #23;
      chk_cnt++; if (ready !== 1'b1) $display("FAIL rst_ready_low: got %b want 1", ready); else pass_cnt++;
      chk_cnt++; if (valid !== 1'b0) $display("FAIL rst_valid_low: got %b want 0", valid); else pass_cnt++;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk_cnt++; if (ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", ready); else pass_cnt++;
      chk_cnt++; if (valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", valid); else pass_cnt++;
      chk_cnt++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else pass_cnt++;
      chk_cnt++; if (data_bus_read !== 16'h0000) $display("FAIL rst_rdata: got %h want 0000", data_bus_read); else pass_cnt++;
   endtask

   task automatic zero_fill();
      int lat, rl;
      logic [DW-1:0] rd, xr;
      logic e, xe;
      for (int i = 0; i < DEPTH; i++) begin
         drive_txn(1'b1, AW'(i), 16'h0000, 2'b11, lat, rl, rd, e);
         model_op(1'b1, AW'(i), 16'h0000, 2'b11, xr, xe);
      end
   endtask

   task automatic test_directed();
      int lat, rl;
      logic [DW-1:0] rd, xr;
      logic e, xe;
      drive_txn(1'b1, 16'h0002, 16'hA5C3, 2'b11, lat, rl, rd, e);
      model_op(1'b1, 16'h0002, 16'hA5C3, 2'b11, xr, xe);
      chk_cnt++; if (lat !== LAT) $display("FAIL dir_wr_latency: got %0d want %0d", lat, LAT); else pass_cnt++;
      chk_cnt++; if (rl !== 3) $display("FAIL dir_wr_ready_low: got %0d want 3", rl); else pass_cnt++;
      chk_cnt++; if (e !== 1'b0) $display("FAIL dir_wr_err: got %b want 0", e); else pass_cnt++;
      drive_txn(1'b0, 16'h0002, 16'h0000, 2'b00, lat, rl, rd, e);
      model_op(1'b0, 16'h0002, 16'h0000, 2'b00, xr, xe);
      chk_cnt++; if (lat !== LAT) $display("FAIL dir_rd_latency: got %0d want %0d", lat, LAT); else pass_cnt++;
      chk_cnt++; if (rd !== 16'hA5C3) $display("FAIL dir_rd_data: got %h want a5c3", rd); else pass_cnt++;
      chk_cnt++; if (e !== 1'b0) $display("FAIL dir_rd_err: got %b want 0", e); else pass_cnt++;
      drive_txn(1'b1, 16'h0002, 16'h1234, 2'b01, lat, rl, rd, e);
      model_op(1'b1, 16'h0002, 16'h1234, 2'b01, xr, xe);
      chk_cnt++; if (rd !== 16'hA5C3) $display("FAIL dir_hold_after_wr: got %h want a5c3", rd); else pass_cnt++;
      drive_txn(1'b0, 16'h0002, 16'h0000, 2'b00, lat, rl, rd, e);
      model_op(1'b0, 16'h0002, 16'h0000, 2'b00, xr, xe);
      chk_cnt++; if (rd !== 16'hA534) $display("FAIL dir_byte_merge: got %h want a534", rd); else pass_cnt++;
   endtask

   task automatic test_random();
      int lat, rl;
      logic [DW-1:0] rd, xr, d;
      logic [AW-1:0] a;
      logic [1:0] be;
      logic e, xe;
      bit wr;
      for (int n = 0; n < 60; n++) begin
         wr = 1'($urandom);
         case ($urandom_range(0, 3))
            0:       a = AW'($urandom);
            1:       a = AW'($urandom_range(0, DEPTH - 1));
            default: a = AW'($urandom_range(0, 7));
         endcase
         d  = DW'($urandom);
         be = 2'($urandom);
         drive_txn(wr, a, d, be, lat, rl, rd, e);
         model_op(wr, a, d, be, xr, xe);
         chk_cnt++; if (lat !== LAT) $display("FAIL rnd_latency op%0d: got %0d want %0d", n, lat, LAT); else pass_cnt++;
         chk_cnt++; if (rd !== xr) $display("FAIL rnd_rdata op%0d addr %h: got %h want %h", n, a, rd, xr); else pass_cnt++;
         chk_cnt++; if (e !== xe) $display("FAIL rnd_err op%0d addr %h: got %b want %b", n, a, e, xe); else pass_cnt++;
         @(negedge clock);
         chk_cnt++; if (valid !== 1'b0) $display("FAIL rnd_valid_pulse op%0d: got %b want 0", n, valid); else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      int lat, rl, rl1, rl2, v1, v2, nvalid;
      logic [DW-1:0] rd, xr, d1, d2;
      logic e, xe;
      bit acc_rdy;
      d1 = DW'($urandom);
      d2 = DW'($urandom);
      rl1 = 0; rl2 = 0; v1 = 0; v2 = 0; nvalid = 0; acc_rdy = 1'b0;
      @(negedge clock);
      req = 1'b1; write = 1'b1; address = 16'h0010; data_bus_write = d1; byte_en = 2'b11;
      @(posedge clock);
      #1;
      address = 16'h0011; data_bus_write = d2;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clock);
         if (!ready) rl1++;
         if (valid) begin nvalid++; if (v1 == 0) v1 = c; acc_rdy = ready; end
      end
      @(posedge clock);
      #1;
      req = 1'b0; address = AW'($urandom); data_bus_write = DW'($urandom);
      for (int c = 5; c <= 10; c++) begin
         @(negedge clock);
         if (!ready) rl2++;
         if (valid) begin nvalid++; if (v2 == 0) v2 = c; end
      end
      model_op(1'b1, 16'h0010, d1, 2'b11, xr, xe);
      model_op(1'b1, 16'h0011, d2, 2'b11, xr, xe);
      chk_cnt++; if (v1 !== 4) $display("FAIL b2b_first_valid: got cycle %0d want 4", v1); else pass_cnt++;
      chk_cnt++; if (acc_rdy !== 1'b1) $display("FAIL b2b_ready_with_valid: got %b want 1", acc_rdy); else pass_cnt++;
      chk_cnt++; if (v2 !== 8) $display("FAIL b2b_second_valid: got cycle %0d want 8", v2); else pass_cnt++;
      chk_cnt++; if (rl1 !== 3) $display("FAIL b2b_ready_low1: got %0d want 3", rl1); else pass_cnt++;
      chk_cnt++; if (rl2 !== 3) $display("FAIL b2b_ready_low2: got %0d want 3", rl2); else pass_cnt++;
      chk_cnt++; if (nvalid !== 2) $display("FAIL b2b_valid_count: got %0d want 2", nvalid); else pass_cnt++;
      drive_txn(1'b0, 16'h0010, 16'h0000, 2'b00, lat, rl, rd, e);
      model_op(1'b0, 16'h0010, 16'h0000, 2'b00, xr, xe);
      chk_cnt++; if (rd !== d1) $display("FAIL b2b_read_0010: got %h want %h", rd, d1); else pass_cnt++;
      drive_txn(1'b0, 16'h0011, 16'h0000, 2'b00, lat, rl, rd, e);
      model_op(1'b0, 16'h0011, 16'h0000, 2'b00, xr, xe);
      chk_cnt++; if (rd !== d2) $display("FAIL b2b_read_0011: got %h want %h", rd, d2); else pass_cnt++;
   endtask

   task automatic test_reset_abort();
      int lat, rl, nvalid;
      logic [DW-1:0] rd, xr;
      logic e, xe;
      drive_txn(1'b1, 16'h0005, 16'h0000, 2'b11, lat, rl, rd, e);
      model_op(1'b1, 16'h0005, 16'h0000, 2'b11, xr, xe);
      drive_txn(1'b0, 16'h0002, 16'h0000, 2'b00, lat, rl, rd, e);
      model_op(1'b0, 16'h0002, 16'h0000, 2'b00, xr, xe);
      @(negedge clock);
      req = 1'b1; write = 1'b1; address = 16'h0005; data_bus_write = 16'hFFFF; byte_en = 2'b11;
      @(posedge clock);
      #1;
      req = 1'b0;
      @(negedge clock);
      #2;
      reset = 1'b0;
      #1;
      chk_cnt++; if (ready !== 1'b1) $display("FAIL abort_ready: got %b want 1", ready); else pass_cnt++;
      chk_cnt++; if (valid !== 1'b0) $display("FAIL abort_valid: got %b want 0", valid); else pass_cnt++;
      chk_cnt++; if (data_bus_read !== 16'h0000) $display("FAIL abort_rdata: got %h want 0000", data_bus_read); else pass_cnt++;
      @(negedge clock);
      reset = 1'b1;
      model_last_rd = '0;
      nvalid = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         if (valid) nvalid++;
      end
      chk_cnt++; if (nvalid !== 0) $display("FAIL abort_no_valid: got %0d pulses want 0", nvalid); else pass_cnt++;
      drive_txn(1'b0, 16'h0005, 16'h0000, 2'b00, lat, rl, rd, e);
      model_op(1'b0, 16'h0005, 16'h0000, 2'b00, xr, xe);
      chk_cnt++; if (rd !== 16'h0000) $display("FAIL abort_no_commit: got %h want 0000", rd); else pass_cnt++;
   endtask

   task automatic test_range();
      int lat, rl;
      logic [DW-1:0] rd, xr, exp_hi;
      logic e, xe;
      exp_hi = RANGE_CHK ? 16'h0000 : 16'hBEEF;
      drive_txn(1'b1, 16'h0000, 16'h0000, 2'b11, lat, rl, rd, e);
      model_op(1'b1, 16'h0000, 16'h0000, 2'b11, xr, xe);
      drive_txn(1'b1, 16'h0200, 16'hBEEF, 2'b11, lat, rl, rd, e);
      model_op(1'b1, 16'h0200, 16'hBEEF, 2'b11, xr, xe);
      chk_cnt++; if (e !== RANGE_CHK) $display("FAIL range_wr_err: got %b want %b", e, RANGE_CHK); else pass_cnt++;
      chk_cnt++; if (lat !== LAT) $display("FAIL range_wr_latency: got %0d want %0d", lat, LAT); else pass_cnt++;
      drive_txn(1'b0, 16'h0200, 16'h0000, 2'b00, lat, rl, rd, e);
      model_op(1'b0, 16'h0200, 16'h0000, 2'b00, xr, xe);
      chk_cnt++; if (e !== RANGE_CHK) $display("FAIL range_rd_err: got %b want %b", e, RANGE_CHK); else pass_cnt++;
      chk_cnt++; if (rd !== exp_hi) $display("FAIL range_rd_data: got %h want %h", rd, exp_hi); else pass_cnt++;
      drive_txn(1'b0, 16'h0000, 16'h0000, 2'b00, lat, rl, rd, e);
      model_op(1'b0, 16'h0000, 16'h0000, 2'b00, xr, xe);
      chk_cnt++; if (e !== 1'b0) $display("FAIL range_word0_err: got %b want 0", e); else pass_cnt++;
      chk_cnt++; if (rd !== exp_hi) $display("FAIL range_word0_data: got %h want %h", rd, exp_hi); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      zero_fill();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_abort();
      test_range();
      repeat (3) @(negedge clock);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

`default_nettype wire
